vram_arbiter: RTL and testbench

//  Shares one async-read/sync-write framebuffer RAM between the VGA scanout reader
//  and a pixel writer, plus a built-in clear/fill engine. Scanout always wins.

---
 rtl/vram_arbiter.sv | 152 +++++++++++++++
 tb/tb_vram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: scanout reads, a queued pixel writer and a
// clear/fill engine share one async-read/sync-write RAM port.
// Scanout always owns the port when it samples; the fill engine runs next,
// and the write FIFO drains only when both are idle.
module vram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int PIX_W      = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          vclk,
  input  logic                          srst,
  input  logic                          scan_req_i,
  input  logic [ADDR_W-1:0]             scan_addr_i,
  output logic [PIX_W-1:0]              scan_pixel_o,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [ADDR_W-1:0]             wr_addr_i,
  input  logic [PIX_W-1:0]              wr_data_i,
  input  logic                          fill_start_i,
  input  logic [PIX_W-1:0]              fill_color_i,
  input  logic [ADDR_W-1:0]             fill_count_i,
  output logic                          fill_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_we_o,
  output logic [PIX_W-1:0]              mem_wdata_o,
  input  logic [PIX_W-1:0]              mem_rdata_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_FILL} fill_st_e;

  fill_st_e          state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [PIX_W-1:0]  color_q, color_d;

  logic [ADDR_W-1:0] fq_addr [FIFO_DEPTH];
  logic [PIX_W-1:0]  fq_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  logic full, empty, push, pop, fill_wr;

  // Readiness comes from the registered level only, so a pop in the same
  // cycle never frees a slot early; reset holds the writer off.
  assign full         = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty        = (level_q == '0);
  assign wr_ready_o   = !srst && !full;
  assign push         = wr_valid_i && wr_ready_o;
  assign fill_wr      = (state_q == ST_FILL) && !scan_req_i && !srst;
  assign pop          = (state_q == ST_IDLE) && !scan_req_i && !empty && !srst;
  assign scan_pixel_o = mem_rdata_i;
  assign fill_busy_o  = (state_q == ST_FILL);
  assign fifo_level_o = level_q;

  // RAM port arbitration: scanout, then fill, then FIFO head.
  always_comb begin
    mem_addr_o  = scan_addr_i;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (!scan_req_i) begin
      if (state_q == ST_FILL) begin
        mem_addr_o  = ptr_q;
        mem_wdata_o = color_q;
        mem_we_o    = !srst;
      end else if (!empty) begin
        mem_addr_o  = fq_addr[rptr_q];
        mem_wdata_o = fq_data[rptr_q];
        mem_we_o    = !srst;
      end
    end
  end

  // Fill engine next state: start only from idle with a non-zero count,
  // advance only on cycles the scanout leaves free.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    color_d = color_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start_i && (fill_count_i != '0)) begin
          color_d = fill_color_i;
          count_d = fill_count_i;
          ptr_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (fill_wr) begin
          if (ptr_q == count_q - ADDR_W'(1)) begin
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers: fill state/pointer and FIFO bookkeeping.
  always_ff @(posedge vclk) begin
    if (srst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Fill parameters latched on an accepted start; data only, no reset.
  always_ff @(posedge vclk) begin
    count_q <= count_d;
    color_q <= color_d;
  end

  // FIFO storage; an entry becomes visible at the head the cycle after push.
  always_ff @(posedge vclk) begin
    if (push) begin
      fq_addr[wptr_q] <= wr_addr_i;
      fq_data[wptr_q] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a queue-based model of the arbitration rules.
module tb_vram_arbiter;

  localparam int AW    = 8;
  localparam int PW    = 3;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MSZ   = 1 << AW;

  logic          vclk = 1'b0;
  logic          srst;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic [PW-1:0] scan_pixel;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          fill_start;
  logic [PW-1:0] fill_color;
  logic [AW-1:0] fill_count;
  logic          fill_busy;
  logic [LW-1:0] fifo_level;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [PW-1:0] mem_wdata;
  logic [PW-1:0] mem_rdata;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [PW-1:0] pre_data;

  logic [PW-1:0] ram     [MSZ];
  logic [PW-1:0] exp_ram [MSZ];
  int            wcnt    [MSZ];

  typedef struct {
    logic [AW-1:0] a;
    logic [PW-1:0] d;
  } wr_t;

  wr_t           q[$];
  bit            f_active;
  int            f_ptr;
  int            f_cnt;
  logic [PW-1:0] f_col;

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.ADDR_W(AW), .PIX_W(PW), .FIFO_DEPTH(DEPTH)) dut (
    .vclk         (vclk),
    .srst         (srst),
    .scan_req_i   (scan_req),
    .scan_addr_i  (scan_addr),
    .scan_pixel_o (scan_pixel),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .fill_start_i (fill_start),
    .fill_color_i (fill_color),
    .fill_count_i (fill_count),
    .fill_busy_o  (fill_busy),
    .fifo_level_o (fifo_level),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 vclk = ~vclk;

  assign mem_rdata = ram[mem_addr];

  // Framebuffer RAM: async read, sync write; also counts writes per address.
  always @(posedge vclk) begin
    if (pre_en) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_we === 1'b1) begin
      ram[mem_addr]  <= mem_wdata;
      wcnt[mem_addr] <= wcnt[mem_addr] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: check outputs against the model, clock, then advance the model.
  task automatic cycle();
    bit was;
    bit rdy;
    #1;
    rdy = !srst && (q.size() < DEPTH);
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, rdy});
    chk("fifo_level", 32'(fifo_level), q.size());
    chk("fill_busy", {31'd0, fill_busy}, {31'd0, f_active});
    if (srst) begin
      chk("we_in_reset", {31'd0, mem_we}, 0);
    end else if (scan_req) begin
      chk("we_scan", {31'd0, mem_we}, 0);
      chk("addr_scan", 32'(mem_addr), 32'(scan_addr));
      chk("scan_pixel", 32'(scan_pixel), 32'(exp_ram[scan_addr]));
    end else if (f_active) begin
      chk("we_fill", {31'd0, mem_we}, 1);
      chk("addr_fill", 32'(mem_addr), f_ptr);
      chk("wdata_fill", 32'(mem_wdata), 32'(f_col));
    end else if (q.size() > 0) begin
      chk("we_fifo", {31'd0, mem_we}, 1);
      chk("addr_fifo", 32'(mem_addr), 32'(q[0].a));
      chk("wdata_fifo", 32'(mem_wdata), 32'(q[0].d));
    end else begin
      chk("we_idle", {31'd0, mem_we}, 0);
      chk("addr_idle", 32'(mem_addr), 32'(scan_addr));
    end
    @(posedge vclk);
    if (srst) begin
      q.delete();
      f_active = 1'b0;
      f_ptr    = 0;
    end else begin
      was = f_active;
      if (!scan_req) begin
        if (was) begin
          exp_ram[f_ptr] = f_col;
          if (f_ptr == f_cnt - 1) f_active = 1'b0;
          else f_ptr++;
        end else if (q.size() > 0) begin
          exp_ram[q[0].a] = q[0].d;
          void'(q.pop_front());
        end
      end
      if (wr_valid && rdy) q.push_back('{a: wr_addr, d: wr_data});
      if (!was && fill_start && (fill_count != 0)) begin
        f_active = 1'b1;
        f_ptr    = 0;
        f_cnt    = int'(fill_count);
        f_col    = fill_color;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    srst       = 1'b0;
    scan_req   = 1'b0;
    wr_valid   = 1'b0;
    fill_start = 1'b0;
  endtask

  initial begin
    int base [6];
    int guard;

    srst = 1'b1; scan_req = 1'b0; scan_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; fill_start = 1'b0; fill_color = '0;
    fill_count = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    f_active = 1'b0; f_ptr = 0; f_cnt = 0; f_col = '0;
    for (int i = 0; i < MSZ; i++) wcnt[i] = 0;
    @(posedge vclk); #1;

    // Preload RAM contents while held in reset.
    for (int i = 0; i < MSZ; i++) begin
      pre_en   = 1'b1;
      pre_addr = AW'(i);
      pre_data = (i == 5) ? PW'(3) : PW'($urandom_range(0, 7));
      exp_ram[i] = pre_data;
      @(posedge vclk); #1;
    end
    pre_en = 1'b0;

    // Reset state.
    cycle();
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_busy", {31'd0, fill_busy}, 0);
    chk("rst_ready", {31'd0, wr_ready}, 0);
    idle_inputs();

    // Scanout read passes RAM data straight through.
    scan_req = 1'b1; scan_addr = AW'(5);
    #1;
    chk("t1_pixel", 32'(scan_pixel), 3);
    chk("t1_we", {31'd0, mem_we}, 0);
    cycle();

    // Writes queue while scanning, then drain in order.
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(10 + i); wr_data = PW'(1 << i);
      cycle();
    end
    wr_valid = 1'b0;
    #1;
    chk("t2_level3", 32'(fifo_level), 3);
    scan_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_drain_we", {31'd0, mem_we}, 1);
      chk("t2_drain_addr", 32'(mem_addr), 10 + i);
      cycle();
    end
    chk("t2_level0", 32'(fifo_level), 0);

    // Full FIFO back-pressure.
    scan_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(20 + i); wr_data = PW'(i);
      cycle();
    end
    wr_addr = AW'(40); wr_data = PW'(7);
    #1;
    chk("t3_full_ready", {31'd0, wr_ready}, 0);
    chk("t3_full_level", 32'(fifo_level), DEPTH);
    cycle();
    scan_req = 1'b0;
    cycle();
    scan_req = 1'b1;
    #1;
    chk("t3_ready_after_pop", {31'd0, wr_ready}, 1);
    chk("t3_level_after_pop", 32'(fifo_level), DEPTH - 1);
    cycle();
    wr_valid = 1'b0;
    #1;
    chk("t3_17th_in", 32'(fifo_level), DEPTH);
    scan_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) cycle();
    chk("t3_drained", 32'(fifo_level), 0);
    chk("t3_last", 32'(ram[40]), 7);

    // Fill with a write pushed mid-fill; the write lands afterwards.
    fill_start = 1'b1; fill_count = AW'(8); fill_color = PW'(5);
    cycle();
    fill_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = (i == 3); wr_addr = AW'(3); wr_data = PW'(2);
      cycle();
    end
    wr_valid = 1'b0;
    #1;
    chk("t4_busy_fell", {31'd0, fill_busy}, 0);
    cycle();
    for (int i = 0; i < 8; i++) chk("t4_mem", 32'(ram[i]), (i == 3) ? 2 : 5);

    // Fill paused by scanout resumes without skipping.
    for (int i = 0; i < 6; i++) base[i] = wcnt[i];
    fill_start = 1'b1; fill_count = AW'(6); fill_color = PW'(6);
    cycle();
    fill_start = 1'b0;
    cycle(); cycle();
    scan_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      scan_addr = AW'($urandom_range(0, MSZ - 1));
      cycle();
    end
    scan_req = 1'b0;
    #1;
    chk("t5_resume_addr", 32'(mem_addr), 2);
    guard = 0;
    while (fill_busy && guard < 20) begin
      cycle();
      guard++;
    end
    chk("t5_done", {31'd0, fill_busy}, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t5_once", wcnt[i] - base[i], 1);
      chk("t5_mem", 32'(ram[i]), 6);
    end

    // Reset during a fill with writes queued.
    fill_start = 1'b1; fill_count = AW'(100); fill_color = PW'(1);
    cycle();
    fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(200 + i); wr_data = PW'(4);
      cycle();
    end
    wr_valid = 1'b0;
    #1;
    chk("t6_level4", 32'(fifo_level), 4);
    chk("t6_busy", {31'd0, fill_busy}, 1);
    srst = 1'b1; fill_start = 1'b1; fill_count = AW'(9);
    cycle();
    idle_inputs();
    #1;
    chk("t6_busy_rst", {31'd0, fill_busy}, 0);
    chk("t6_level_rst", 32'(fifo_level), 0);
    chk("t6_we_rst", {31'd0, mem_we}, 0);
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      srst       = ($urandom_range(0, 99) == 0);
      scan_req   = ($urandom_range(0, 1) == 1);
      scan_addr  = AW'($urandom_range(0, MSZ - 1));
      wr_valid   = ($urandom_range(0, 2) != 0);
      wr_addr    = AW'($urandom_range(0, MSZ - 1));
      wr_data    = PW'($urandom_range(0, 7));
      fill_start = ($urandom_range(0, 29) == 0);
      fill_count = AW'($urandom_range(0, 12));
      fill_color = PW'($urandom_range(0, 7));
      cycle();
    end
    idle_inputs();
    guard = 0;
    while ((fill_busy || fifo_level != 0) && guard < 300) begin
      cycle();
      guard++;
    end
    chk("rand_quiesce", {31'd0, fill_busy}, 0);
    for (int i = 0; i < MSZ; i++) chk("rand_mem", 32'(ram[i]), 32'(exp_ram[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
